// File: rtl/disp_mux_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : disp_pkg
// Purpose : Shared types and constants for the display multiplex scheduler.
//           Holds the scheduler state encoding, the digit nibble width, the
//           default dwell/blank lengths for a 48 MHz clock, and a helper that
//           sizes the shared phase timer.
// Revision: 1.0 - initial release
// ============================================================================
package disp_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } disp_state_t;

  localparam int DISP_NIBBLE_W      = 4;

  // 48 MHz: 24000 cycles = 500 us on, 240 cycles = 5 us blank per slot
  localparam int DISP_DWELL_DEFAULT = 24000;
  localparam int DISP_BLANK_DEFAULT = 240;

  // Timer must hold values 0..max_count-1; sized as clog2(max_count+1)
  function automatic int timer_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage : disp_pkg
`default_nettype wire

// File: rtl/disp_mux_ctrl_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module  : cycle_timer
// Purpose : Up-counter shared by the blank and drive phases. The terminal
//           value is supplied at run time so one counter serves both phases.
// Ports   : clk     - system clock
//           reset_n - asynchronous active-low reset (count -> 0)
//           clear   - synchronous clear, wins over en
//           en      - count enable
//           last    - terminal value (phase length - 1)
//           tc      - high while count equals last
// Revision: 1.0 - initial release
// ============================================================================
module cycle_timer
  import disp_pkg::*;
#(
  parameter  int MAX = DISP_DWELL_DEFAULT,
  localparam int W   = timer_width(MAX)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tc = (r_count == last);

endmodule : cycle_timer
`default_nettype wire

// File: rtl/disp_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : disp_mux_ctrl
// Purpose : Time-multiplex scheduler sharing one hex decoder across N_DIGITS
//           common-anode displays. Every slot blanks all anodes, latches the
//           slot's nibble, then drives one anode for a dwell period, so the
//           decoder input never changes while an anode is on.
// Ports   : clk        - system clock
//           reset_n    - asynchronous active-low reset
//           en         - 1 = scan running, 0 = all displays blanked
//           digits_in  - packed digit nibbles, digit k at [4k+3:4k]
//           dec_s      - registered nibble to the decoder
//           anode_n    - registered active-low anode enables (<=1 low)
//           slot_idx   - current / next digit index
//           frame_tick - one-cycle pulse after the last digit's dwell
// Revision: 1.0 - initial release
// ============================================================================
module disp_mux_ctrl
  import disp_pkg::*;
#(
  parameter int N_DIGITS     = 2,
  parameter int DWELL_CYCLES = DISP_DWELL_DEFAULT,
  parameter int BLANK_CYCLES = DISP_BLANK_DEFAULT
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              en,
  input  logic [DISP_NIBBLE_W*N_DIGITS-1:0] digits_in,
  output logic [DISP_NIBBLE_W-1:0]          dec_s,
  output logic [N_DIGITS-1:0]               anode_n,
  output logic [$clog2(N_DIGITS)-1:0]       slot_idx,
  output logic                              frame_tick
);

  localparam int c_SLOT_W    = $clog2(N_DIGITS);
  localparam int c_TIMER_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int c_TIMER_W   = timer_width(c_TIMER_MAX);
  localparam int c_NIB_SLOTS = 2 ** c_SLOT_W;

  if (N_DIGITS < 2) begin : g_err_digits
    $error("disp_mux_ctrl: N_DIGITS must be >= 2");
  end
  if (DWELL_CYCLES < 1) begin : g_err_dwell
    $error("disp_mux_ctrl: DWELL_CYCLES must be >= 1");
  end
  if (BLANK_CYCLES < 1) begin : g_err_blank
    $error("disp_mux_ctrl: BLANK_CYCLES must be >= 1");
  end

  disp_state_t                r_state;
  logic [c_SLOT_W-1:0]        r_slot;
  logic [N_DIGITS-1:0]        r_anode_n;
  logic [DISP_NIBBLE_W-1:0]   r_dec;
  logic                       r_frame_tick;

  logic [DISP_NIBBLE_W-1:0]   w_nibble [c_NIB_SLOTS];
  logic [N_DIGITS-1:0]        w_drive_n;
  logic [c_TIMER_W-1:0]       w_last;
  logic                       w_tc_raw;
  logic                       w_tc;
  logic                       w_slot_last;
  logic [c_SLOT_W-1:0]        w_slot_next;

  // Pad the nibble table to a power of two so any slot index is in range
  for (genvar k = 0; k < c_NIB_SLOTS; k++) begin : g_nibble
    if (k < N_DIGITS) begin : g_real
      assign w_nibble[k] = digits_in[DISP_NIBBLE_W*k +: DISP_NIBBLE_W];
    end else begin : g_pad
      assign w_nibble[k] = '1;
    end
  end

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_anode
    assign w_drive_n[k] = (r_slot != c_SLOT_W'(k));
  end

  assign w_last = (r_state == S_BLANK) ? c_TIMER_W'(BLANK_CYCLES - 1)
                                       : c_TIMER_W'(DWELL_CYCLES - 1);

  // A terminal count only counts while running; en=0 overrides any advance
  assign w_tc        = en && w_tc_raw;
  assign w_slot_last = (r_slot == c_SLOT_W'(N_DIGITS - 1));
  assign w_slot_next = w_slot_last ? '0 : r_slot + 1'b1;

  cycle_timer #(
    .MAX (c_TIMER_MAX)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!en || w_tc),
    .en      (en),
    .last    (w_last),
    .tc      (w_tc_raw)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_BLANK;
      r_slot       <= '0;
      r_anode_n    <= '1;
      r_dec        <= '1;
      r_frame_tick <= 1'b0;
    end else if (!en) begin
      // Slot and nibble are kept so the scan resumes on the same digit
      r_state      <= S_BLANK;
      r_anode_n    <= '1;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      if (r_state == S_BLANK) begin
        r_anode_n <= '1;
        if (w_tc) begin
          // Nibble and anode switch on the same edge; nibble then holds
          r_dec     <= w_nibble[r_slot];
          r_anode_n <= w_drive_n;
          r_state   <= S_DRIVE;
        end
      end else begin
        r_anode_n <= w_drive_n;
        if (w_tc) begin
          r_anode_n    <= '1;
          r_slot       <= w_slot_next;
          r_frame_tick <= w_slot_last;
          r_state      <= S_BLANK;
        end
      end
    end
  end

  assign dec_s      = r_dec;
  assign anode_n    = r_anode_n;
  assign slot_idx   = r_slot;
  assign frame_tick = r_frame_tick;

endmodule : disp_mux_ctrl
`default_nettype wire
